vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_in_sync.sv | 52 +++++
 rtl/vga_rx_monitor.sv | 155 +++++++++++++++
 tb/tb_vga_rx_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480 timing constants, TinyVGA pin indices and the lock
//                state encoding shared by the receiver and the sync generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Horizontal / vertical timing (clocks per line, lines per frame)
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_HS_START = 656;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_VS_START = 490;
  localparam int VGA_TIMEOUT  = 1023;

  // TinyVGA pin positions within the 8-bit connector
  localparam int PIN_R1 = 0;
  localparam int PIN_G1 = 1;
  localparam int PIN_B1 = 2;
  localparam int PIN_VS = 3;
  localparam int PIN_R0 = 4;
  localparam int PIN_G0 = 5;
  localparam int PIN_B0 = 6;
  localparam int PIN_HS = 7;

  // Idle connector value: both active-low syncs high, colour off
  localparam logic [7:0] SYNC_IDLE = 8'h88;

  typedef enum logic [1:0] {
    LOCK_HUNT   = 2'd0,
    LOCK_ALIGN  = 2'd1,
    LOCK_LOCKED = 2'd2
  } lock_state_e;

  // Gather the scattered colour pins into {R1,R0,G1,G0,B1,B0}
  function automatic logic [5:0] pins_to_rgb(input logic [7:0] pins);
    return {pins[PIN_R1], pins[PIN_R0], pins[PIN_G1],
            pins[PIN_G0], pins[PIN_B1], pins[PIN_B0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : vga_in_sync
//  Description : Two-flop synchronizer on all TinyVGA pins, an extra delay
//                stage on both syncs, and falling-edge detection of the syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_in_sync
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic [5:0] rgb,
  output logic       hs_fall,
  output logic       vs_fall
);

  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;
  logic       s3_hs_q, s3_hs_d;
  logic       s3_vs_q, s3_vs_d;

  // Shift every pin one stage per clock; only the syncs get the third stage
  always_comb begin
    s1_d    = vga_in;
    s2_d    = s1_q;
    s3_hs_d = s2_q[PIN_HS];
    s3_vs_d = s2_q[PIN_VS];
  end

  // Synchronizer registers; syncs reset to their inactive (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= SYNC_IDLE;
      s2_q    <= SYNC_IDLE;
      s3_hs_q <= 1'b1;
      s3_vs_q <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_hs_q <= s3_hs_d;
      s3_vs_q <= s3_vs_d;
    end
  end

  assign hs_fall = ~s2_q[PIN_HS] & s3_hs_q;
  assign vs_fall = ~s2_q[PIN_VS] & s3_vs_q;
  assign rgb     = pins_to_rgb(s2_q);

endmodule
`default_nettype wire

// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_monitor
//  Description : Recovers pixel coordinates from a TinyVGA stream, tracks
//                timing lock, counts frames / timing errors and samples the
//                colour at a programmable probe coordinate.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int HS_START = VGA_HS_START,
  parameter int VS_START = VGA_VS_START,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int TIMEOUT  = VGA_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic       locked,
  output logic [9:0] rx_hpos,
  output logic [9:0] rx_vpos,
  output logic       rx_de,
  output logic [5:0] rx_rgb,
  output logic [5:0] probe_rgb,
  output logic       probe_stb,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_POS   = 10'(HS_START);
  localparam logic [9:0] HS_LOAD  = 10'(HS_START + 1);
  localparam logic [9:0] VS_POS   = 10'(VS_START);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] TMO_MAX  = 10'(TIMEOUT);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  logic [5:0]  s2_rgb;
  logic        hs_fall, vs_fall;

  logic [9:0]  hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic [9:0]  timeout_q, timeout_d;
  lock_state_e state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [5:0]  probe_rgb_q, probe_rgb_d;
  logic        probe_stb_q, probe_stb_d;

  logic        h_wrap, timing_err;

  vga_in_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .vga_in  (vga_in),
    .rgb     (s2_rgb),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall)
  );

  // Coordinate recovery, error detection and timeout counting
  always_comb begin
    h_wrap     = (hpos_q == H_LAST) && !hs_fall;
    timing_err = (hs_fall && (hpos_q != HS_POS))
               || (vs_fall && ((vpos_q != VS_POS) || (hpos_q != 10'd0)))
               || (!hs_fall && (timeout_q == TMO_LAST));

    // An hsync edge re-aligns the column to the pixel after HS_START
    if (hs_fall)     hpos_d = HS_LOAD;
    else if (h_wrap) hpos_d = 10'd0;
    else             hpos_d = hpos_q + 10'd1;

    // A vsync edge wins over the end-of-line row advance
    vpos_d = vpos_q;
    if (vs_fall)     vpos_d = VS_POS;
    else if (h_wrap) vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;

    // Counts clocks since the last hsync edge and parks at the limit
    if (hs_fall)                     timeout_d = 10'd0;
    else if (timeout_q == TMO_MAX)   timeout_d = timeout_q;
    else                             timeout_d = timeout_q + 10'd1;
  end

  // Lock FSM, statistics counters and probe capture
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    probe_rgb_d = probe_rgb_q;
    probe_stb_d = 1'b0;

    case (state_q)
      LOCK_HUNT:   if (vs_fall) state_d = LOCK_ALIGN;
      LOCK_ALIGN:  if (timing_err) state_d = LOCK_HUNT;
                   else if (vs_fall) state_d = LOCK_LOCKED;
      LOCK_LOCKED: if (timing_err) state_d = LOCK_HUNT;
      default:     state_d = LOCK_HUNT;
    endcase

    // Errors seen while still hunting are expected and not counted
    if (timing_err && (state_q != LOCK_HUNT) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;

    if (vs_fall && (state_q == LOCK_LOCKED))
      frame_cnt_d = frame_cnt_q + 8'd1;

    if ((state_q == LOCK_LOCKED) && (hpos_q == probe_x) && (vpos_q == probe_y)) begin
      probe_rgb_d = s2_rgb;
      probe_stb_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q      <= 10'd0;
      vpos_q      <= 10'd0;
      timeout_q   <= 10'd0;
      state_q     <= LOCK_HUNT;
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
      probe_rgb_q <= 6'd0;
      probe_stb_q <= 1'b0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      timeout_q   <= timeout_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      probe_rgb_q <= probe_rgb_d;
      probe_stb_q <= probe_stb_d;
    end
  end

  assign locked    = (state_q == LOCK_LOCKED);
  assign rx_hpos   = hpos_q;
  assign rx_vpos   = vpos_q;
  assign rx_de     = locked && (hpos_q < H_ACT) && (vpos_q < V_ACT);
  assign rx_rgb    = rx_de ? s2_rgb : 6'd0;
  assign probe_rgb = probe_rgb_q;
  assign probe_stb = probe_stb_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rx_monitor
//  Description : Directed self-checking bench for vga_rx_monitor using a
//                scaled-down raster (40x30 total, 32x24 active).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rx_monitor;

  localparam int TH  = 40;   // clocks per line
  localparam int TV  = 30;   // lines per frame
  localparam int THA = 32;
  localparam int TVA = 24;
  localparam int TSH = 34;   // hsync low from this column
  localparam int TSV = 26;   // vsync low from this line
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int TTO = 63;
  localparam int PX  = 16;
  localparam int PY  = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vga_in;
  logic [9:0] probe_x, probe_y;
  logic       locked, rx_de, probe_stb;
  logic [9:0] rx_hpos, rx_vpos;
  logic [5:0] rx_rgb, probe_rgb;
  logic [7:0] frame_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  // Generator state: pixel currently driven, plus two-deep history
  int gx, gy, vs_edges;
  int hx [3];
  int hy [3];
  bit gen_short, gen_hs_hold, manual;

  vga_rx_monitor #(
    .H_TOTAL (TH), .V_TOTAL (TV), .HS_START(TSH), .VS_START(TSV),
    .H_ACTIVE(THA), .V_ACTIVE(TVA), .TIMEOUT (TTO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_in    (vga_in),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .locked    (locked),
    .rx_hpos   (rx_hpos),
    .rx_vpos   (rx_vpos),
    .rx_de     (rx_de),
    .rx_rgb    (rx_rgb),
    .probe_rgb (probe_rgb),
    .probe_stb (probe_stb),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // {R1,R0,G1,G0,B1,B0} plus syncs onto TinyVGA pin order
  function automatic logic [7:0] pins(input logic [5:0] c, input logic hs, input logic vs);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // Test pattern: never zero, except the fixed probe colour at (PX,PY)
  function automatic logic [5:0] color(input int x, input int y);
    if (x == PX && y == PY) return 6'b101101;
    return 6'((x + 3 * y) | 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_pixel();
    logic hs, vs;
    hs = !((gx >= TSH) && (gx < TSH + HSW)) || gen_hs_hold;
    vs = !((gy >= TSV) && (gy < TSV + VSW));
    vga_in = pins(color(gx, gy), hs, vs);
    if (gx == 0 && gy == TSV) vs_edges++;
  endtask

  task automatic advance();
    int end_x;
    end_x = gen_short ? TH - 2 : TH - 1;
    if (gx >= end_x) begin
      gx = 0;
      gen_short = 1'b0;
      gy = (gy == TV - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  // One clock: sample point is #1 after the edge, then the next pixel goes out
  task automatic step();
    @(posedge clk);
    #1;
    if (!manual) begin
      advance();
      drive_pixel();
      hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = gx;
      hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = gy;
    end
  endtask

  // Run until n more vsync edges are driven, then let them reach the FSM
  task automatic run_vs(input int n);
    int target;
    target = vs_edges + n;
    for (int i = 0; i < n * TH * TV + 10 && vs_edges < target; i++) step();
    if (vs_edges < target) begin
      checks++; errors++;
      $error("FAIL vs_wait: observed=%0d expected=%0d", vs_edges, target);
    end
    repeat (3) step();
  endtask

  task automatic run_until(input int x, input int y);
    for (int i = 0; i < 2 * TH * TV && !(gx == x && gy == y); i++) step();
    if (!(gx == x && gy == y)) begin
      checks++; errors++;
      $error("FAIL pos_wait: observed=%0d,%0d expected=%0d,%0d", gx, gy, x, y);
    end
  endtask

  task automatic count_stb(output int n, output logic [5:0] last);
    n = 0;
    last = 6'd0;
    for (int i = 0; i < TH * TV; i++) begin
      step();
      if (probe_stb) begin n++; last = probe_rgb; end
    end
  endtask

  initial begin
    int          n;
    logic [5:0]  cap;

    rst_n = 1'b0; vga_in = 8'h88;
    probe_x = 10'(PX); probe_y = 10'(PY);
    gx = TH - 1; gy = TV - 1; vs_edges = 0;
    gen_short = 1'b0; gen_hs_hold = 1'b0; manual = 1'b0;
    for (int i = 0; i < 3; i++) begin hx[i] = 0; hy[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_hpos", 32'(rx_hpos), 0);
    check("rst_vpos", 32'(rx_vpos), 0);
    check("rst_frame", 32'(frame_cnt), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_stb", 32'(probe_stb), 0);
    check("rst_de", 32'(rx_de), 0);
    rst_n = 1'b1;

    // Clean stream: ALIGN after 1st vsync, LOCKED after 2nd, 1 frame after 3rd
    run_vs(1);
    check("lock_vs1", 32'(locked), 0);
    run_vs(1);
    check("lock_vs2", 32'(locked), 1);
    check("frame_vs2", 32'(frame_cnt), 0);
    run_vs(1);
    check("lock_vs3", 32'(locked), 1);
    check("frame_vs3", 32'(frame_cnt), 1);
    check("err_clean", 32'(err_cnt), 0);
    check("hpos_align", 32'(rx_hpos), 32'(hx[2]));
    check("vpos_align", 32'(rx_vpos), 32'(hy[2]));

    // Probe in the active area: one strobe per frame with the probe colour
    count_stb(n, cap);
    check("stb_per_frame", 32'(n), 1);
    check("probe_rgb", 32'(cap), 32'(6'b101101));
    run_until(PX, PY);
    step(); step();
    check("de_active", 32'(rx_de), 1);
    check("rgb_active", 32'(rx_rgb), 32'(6'b101101));
    step();
    check("stb_timing", 32'(probe_stb), 1);
    run_until(TH - 2, 5);
    step(); step();
    check("de_blank", 32'(rx_de), 0);
    check("rgb_blank", 32'(rx_rgb), 0);

    // Probe in the blanking area still samples: (36 + 3*28) | 1 -> 6'b111001
    probe_x = 10'd36; probe_y = 10'd28;
    count_stb(n, cap);
    check("stb_blank_probe", 32'(n), 1);
    check("rgb_blank_probe", 32'(cap), 32'(6'b111001));
    probe_x = 10'(PX); probe_y = 10'(PY);

    // Line 5 shortened by one clock: error at the hsync of line 6
    run_until(0, 5);
    gen_short = 1'b1;
    run_until(TSH, 6);
    step(); step();
    check("lock_pre_err", 32'(locked), 1);
    step();
    check("lock_post_err", 32'(locked), 0);
    check("err_short", 32'(err_cnt), 1);
    run_vs(1);
    check("relock_vs1", 32'(locked), 0);
    run_vs(1);
    check("relock_vs2", 32'(locked), 1);
    check("err_relock", 32'(err_cnt), 1);

    // Asynchronous reset mid-line while locked
    run_until(10, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 0);
    check("arst_hpos", 32'(rx_hpos), 0);
    check("arst_vpos", 32'(rx_vpos), 0);
    check("arst_de", 32'(rx_de), 0);
    check("arst_rgb", 32'(rx_rgb), 0);
    check("arst_frame", 32'(frame_cnt), 0);
    check("arst_err", 32'(err_cnt), 0);
    check("arst_probe_rgb", 32'(probe_rgb), 0);
    check("arst_stb", 32'(probe_stb), 0);
    step(); step();
    rst_n = 1'b1;
    run_vs(1);
    check("arst_vs1", 32'(locked), 0);
    run_vs(1);
    check("arst_vs2", 32'(locked), 1);
    check("arst_err_after", 32'(err_cnt), 0);

    // hsync stuck high for 100 clocks: one timeout error, none after
    run_until(0, 2);
    gen_hs_hold = 1'b1;
    repeat (100) step();
    gen_hs_hold = 1'b0;
    check("stall_locked", 32'(locked), 0);
    check("stall_err", 32'(err_cnt), 1);
    run_until(0, 10);
    check("stall_err_hold", 32'(err_cnt), 1);
    check("stall_hunt", 32'(locked), 0);

    // Alternate vsync / hsync pulses: each misplaced hsync in ALIGN is an error
    manual = 1'b1;
    for (int i = 0; i < 300; i++) begin
      vga_in = 8'h80; step(); step();
      vga_in = 8'h88; step(); step();
      vga_in = 8'h08; step(); step();
      vga_in = 8'h88; step(); step();
    end
    repeat (4) step();
    check("err_saturate", 32'(err_cnt), 255);
    check("sat_locked", 32'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
